// File: rtl/msm_operand_router_pkg.sv
// Shared definitions for the MSM operand router.
// Source indices, bubble select code, point width helper, FSM states.
package msm_operand_router_pkg;

  localparam int SRC_RB    = 0;
  localparam int SRC_PM    = 1;
  localparam int SRC_BKT_A = 2;
  localparam int SRC_BKT_B = 3;

  // Any select >= N_SRC reads as a bubble; this is the
  // canonical code for the default four sources.
  localparam int SEL_BUBBLE = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    LD_NONE   = 2'd0,
    LD_ISSUE  = 2'd1,
    LD_BUBBLE = 2'd2
  } load_t;

  function automatic int point_w(
    input int wid,
    input int wdata
  );
    return wid + 3 * wdata;
  endfunction

endpackage

// File: rtl/msm_operand_mux.sv
// N_SRC:1 point select; out-of-range select yields an all-zero bubble.
// Ports: data (packed sources), sel, pt (selected point), hit (one-hot source used).
module msm_operand_mux
  import msm_operand_router_pkg::*;
#(
  parameter int W     = point_w(2, 384),
  parameter int N_SRC = 4,
  parameter int SEL_W = $clog2(N_SRC + 1)
) (
  input  logic [N_SRC*W-1:0] data,
  input  logic [SEL_W-1:0]   sel,
  output logic [W-1:0]       pt,
  output logic [N_SRC-1:0]   hit
);

  always_comb begin
    pt  = '0;
    hit = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        pt     = data[i*W +: W];
        hit[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msm_operand_router.sv
// Routes operand pairs from point sources to a single registered adder slot.
// Ports: src_* sources, cmd_* route/drain commands, padd_* adder output, busy, counters.
module msm_operand_router
  import msm_operand_router_pkg::*;
#(
  parameter int WIDTH_ID   = 2,
  parameter int WIDTH_DATA = 384,
  parameter int N_SRC      = 4,
  parameter int CNT_W      = 8,
  localparam int W         = point_w(WIDTH_ID, WIDTH_DATA),
  localparam int SEL_W     = $clog2(N_SRC + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SRC*W-1:0] src_data,
  input  logic [N_SRC-1:0]   src_valid,
  output logic [N_SRC-1:0]   src_ready,
  input  logic [SEL_W-1:0]   cmd_sel_a,
  input  logic [SEL_W-1:0]   cmd_sel_b,
  input  logic               cmd_drain,
  input  logic [CNT_W-1:0]   cmd_cnt,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic [W-1:0]       padd_a,
  output logic [W-1:0]       padd_b,
  output logic               padd_valid,
  input  logic               padd_ready,
  output logic               busy,
  output logic [31:0]        issue_cnt,
  output logic [31:0]        bubble_cnt
);

  state_t             state;
  logic [CNT_W-1:0]   remaining;
  logic [W-1:0]       pt_a;
  logic [W-1:0]       pt_b;
  logic [N_SRC-1:0]   hit_a;
  logic [N_SRC-1:0]   hit_b;
  logic [N_SRC-1:0]   need;
  logic               srcs_ok;
  logic               free;
  logic               idle;
  logic               acc;
  logic               acc_route;
  logic               acc_drain;
  logic               drain_ld;
  logic               both_bub;
  load_t              ld;

  msm_operand_mux #(
    .W     (W),
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_mux_a (
    .data (src_data),
    .sel  (cmd_sel_a),
    .pt   (pt_a),
    .hit  (hit_a)
  );

  msm_operand_mux #(
    .W     (W),
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_mux_b (
    .data (src_data),
    .sel  (cmd_sel_b),
    .pt   (pt_b),
    .hit  (hit_b)
  );

  // Same source on both sides ORs into one bit: consumed once.
  assign need     = hit_a | hit_b;
  assign srcs_ok  = (need & ~src_valid) == '0;
  assign both_bub = need == '0;
  assign free     = !padd_valid || padd_ready;
  assign idle     = state == ST_IDLE;

  assign cmd_ready = rst_n && idle && free
                   && (cmd_drain || srcs_ok);
  assign acc       = cmd_valid && cmd_ready;
  assign acc_route = acc && !cmd_drain;
  assign acc_drain = acc && cmd_drain;
  assign drain_ld  = (state == ST_DRAIN) && free;

  assign src_ready = acc_route ? need : '0;
  assign busy      = !idle || padd_valid;

  always_comb begin
    ld = LD_NONE;
    unique case (1'b1)
      acc_route && !both_bub: ld = LD_ISSUE;
      acc_route && both_bub:  ld = LD_BUBBLE;
      drain_ld:               ld = LD_BUBBLE;
      default:                ld = LD_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      padd_a     <= '0;
      padd_b     <= '0;
      padd_valid <= 1'b0;
      issue_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (free) begin
        padd_valid <= ld != LD_NONE;
        if (ld == LD_ISSUE) begin
          padd_a    <= pt_a;
          padd_b    <= pt_b;
          issue_cnt <= issue_cnt + 32'd1;
        end
        if (ld == LD_BUBBLE) begin
          padd_a     <= '0;
          padd_b     <= '0;
          bubble_cnt <= bubble_cnt + 32'd1;
        end
      end
      case (state)
        ST_IDLE: begin
          if (acc_drain && cmd_cnt != '0) begin
            state     <= ST_DRAIN;
            remaining <= cmd_cnt;
          end
        end
        ST_DRAIN: begin
          if (free) begin
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
